// File: rtl/serial_adder.sv
// serial_adder: bit-serial LSB-first adder around one fullAdder cell with start/done handshake.
// Optional build macro SERIAL_ADDER_SUB_EN adds a `sub` port selecting a - b (two's complement).

// fullAdder: single-bit full adder cell.
module fullAdder (
   input  logic i_x,
   input  logic i_y,
   input  logic i_cin,
   output logic o_sum,
   output logic o_cout
);
   assign o_sum  = i_x ^ i_y ^ i_cin;
   assign o_cout = (i_x & i_y) | (i_cin & (i_x ^ i_y));
endmodule

module serial_adder #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             busy,
   output logic             done
`ifdef SERIAL_ADDER_SUB_EN
   ,
   input  logic             sub
`endif
);
   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           r_state;
   logic [WIDTH-1:0] r_a_sr;
   logic [WIDTH-1:0] r_b_sr;
   logic [WIDTH-1:0] r_acc_sr;
   logic             r_carry;
   logic [CW-1:0]    r_cnt;
   logic [WIDTH-1:0] r_sum;
   logic             r_cout;
   logic             r_busy;
   logic             r_done;

   logic             w_sum;
   logic             w_cout;
   logic [WIDTH-1:0] w_acc_nxt;
   logic [WIDTH-1:0] w_b_ld;
   logic             w_c_ld;

`ifdef SERIAL_ADDER_SUB_EN
   // Subtraction loads ~b with a forced carry-in of 1, giving a + ~b + 1.
   assign w_b_ld = sub ? ~b : b;
   assign w_c_ld = sub | cin;
`else
   assign w_b_ld = b;
   assign w_c_ld = cin;
`endif

   fullAdder u_fa (
      .i_x   (r_a_sr[0]),
      .i_y   (r_b_sr[0]),
      .i_cin (r_carry),
      .o_sum (w_sum),
      .o_cout(w_cout)
   );

   assign w_acc_nxt = (r_acc_sr >> 1) | {w_sum, {(WIDTH-1){1'b0}}};

   assign sum  = r_sum;
   assign cout = r_cout;
   assign busy = r_busy;
   assign done = r_done;

   // Control FSM with datapath shifting; results publish only on entry to DONE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= IDLE;
         r_a_sr   <= '0;
         r_b_sr   <= '0;
         r_acc_sr <= '0;
         r_carry  <= 1'b0;
         r_cnt    <= '0;
         r_sum    <= '0;
         r_cout   <= 1'b0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_a_sr  <= a;
                  r_b_sr  <= w_b_ld;
                  r_carry <= w_c_ld;
                  r_cnt   <= '0;
                  r_state <= RUN;
                  r_busy  <= 1'b1;
               end
            end
            RUN: begin
               r_a_sr   <= r_a_sr >> 1;
               r_b_sr   <= r_b_sr >> 1;
               r_acc_sr <= w_acc_nxt;
               r_carry  <= w_cout;
               if (r_cnt == CW'(WIDTH-1)) begin
                  r_sum   <= w_acc_nxt;
                  r_cout  <= w_cout;
                  r_state <= DONE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            default: begin
               r_state <= IDLE;
               r_done  <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: randomized self-checking bench for serial_adder (WIDTH=8) against an arithmetic model.
module tb_serial_adder;
   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         cin = 1'b0;
   logic [W-1:0] sum;
   logic         cout;
   logic         busy;
   logic         done;
`ifdef SERIAL_ADDER_SUB_EN
   logic         sub = 1'b0;
`endif

   int n_checks = 0;
   int n_fail = 0;

   serial_adder #(.WIDTH(W)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .start(start),
      .a    (a),
      .b    (b),
      .cin  (cin),
      .sum  (sum),
      .cout (cout),
      .busy (busy),
      .done (done)
`ifdef SERIAL_ADDER_SUB_EN
      ,
      .sub  (sub)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [W:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                        input logic mc, input logic ms);
      int r;
      r = ms ? (int'(ma) + (1 << W) - int'(mb)) : (int'(ma) + int'(mb) + int'(mc));
      return (W+1)'(r % (1 << (W+1)));
   endfunction

   // One full operation: accept, hold checks through RUN with scrambled operands, result on DONE.
   task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc, input logic ts);
      logic [W:0] exp;
      logic [W:0] prev;
      exp = model(ta, tb, tc, ts);
      @(negedge clk);
      a = ta; b = tb; cin = tc; start = 1'b1;
`ifdef SERIAL_ADDER_SUB_EN
      sub = ts;
`endif
      prev = {cout, sum};
      @(posedge clk); #1;
      start = 1'b0;
      check("busy_after_accept", busy, 1);
      for (int k = 1; k <= W; k++) begin
         check("hold_during_run", {cout, sum}, prev);
         a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
`ifdef SERIAL_ADDER_SUB_EN
         sub = 1'($urandom);
`endif
         @(posedge clk); #1;
         if (k < W) begin
            check("busy_run", busy, 1);
            check("done_early", done, 0);
         end
      end
      check("done_pulse", done, 1);
      check("busy_in_done", busy, 0);
      check("result", {cout, sum}, exp);
      @(posedge clk); #1;
      check("done_one_cycle", done, 0);
      check("result_held", {cout, sum}, exp);
   endtask

   initial begin
      int accepts [$];
      int cyc;
      int dcount;
      logic pbusy;
      #12;
      check("rst_sum", sum, 0);
      check("rst_cout", cout, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      @(negedge clk); rst_n = 1'b1;

      do_op(8'h00, 8'h00, 1'b0, 1'b0);
      do_op(8'hFF, 8'h01, 1'b0, 1'b0);
      do_op(8'hA5, 8'h5A, 1'b1, 1'b0);
      do_op(8'h3C, 8'h41, 1'b0, 1'b0);
      check("plan_7d", sum, 8'h7D);
      do_op(8'h10, 8'h20, 1'b0, 1'b0);
      check("plan_30", sum, 8'h30);

      // start held high: accepts every W+2 cycles, operands scrambled while busy
      @(negedge clk);
      a = 8'h01; b = 8'h01; cin = 1'b0; start = 1'b1;
      pbusy = busy;
      cyc = 0;
      while (accepts.size() < 3 && cyc < 60) begin
         @(posedge clk); #1;
         cyc++;
         if (busy && !pbusy) accepts.push_back(cyc);
         if (done) check("cont_result", {cout, sum}, 9'h002);
         pbusy = busy;
         if (busy) begin a = W'($urandom); b = W'($urandom); cin = 1'($urandom); end
         else begin a = 8'h01; b = 8'h01; cin = 1'b0; end
      end
      start = 1'b0;
      check("cont_accepts", accepts.size(), 3);
      if (accepts.size() == 3) begin
         check("cont_gap1", accepts[1] - accepts[0], W + 2);
         check("cont_gap2", accepts[2] - accepts[1], W + 2);
      end
      repeat (W + 3) @(posedge clk);

      // reset in the middle of an operation
      @(negedge clk);
      a = 8'hFF; b = 8'h01; cin = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (4) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("midrst_sum", sum, 0);
      check("midrst_cout", cout, 0);
      check("midrst_busy", busy, 0);
      check("midrst_done", done, 0);
      @(negedge clk); rst_n = 1'b1;
      dcount = 0;
      repeat (15) begin @(posedge clk); #1; if (done || busy) dcount++; end
      check("no_done_after_rst", dcount, 0);
      do_op(8'h12, 8'h34, 1'b1, 1'b0);

`ifdef SERIAL_ADDER_SUB_EN
      do_op(8'h05, 8'h07, 1'b0, 1'b1);
      check("sub_fe", {cout, sum}, 9'h0FE);
      do_op(8'h07, 8'h05, 1'b1, 1'b1);
      check("sub_102", {cout, sum}, 9'h102);
`endif

      // randomized operations, including boundary operands
      do_op(8'hFF, 8'hFF, 1'b1, 1'b0);
      for (int i = 0; i < 20; i++)
`ifdef SERIAL_ADDER_SUB_EN
         do_op(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
`else
         do_op(W'($urandom), W'($urandom), 1'($urandom), 1'b0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
